// File: rtl/load_hold_register.sv
// rtl/load_hold_register.sv - WIDTH-bit register of mux+dff cells; load captures d, otherwise hold
// Reset has priority over load; q_n is a pure combinational inversion of q.

module lhr_mux2 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module lhr_dff_sc #(
  parameter logic CLR_VALUE = 1'b0
) (
  input  logic clk,
  input  logic clr_n_i,
  input  logic d_i,
  output logic q_o
);
  logic bit_q;

  always_ff @(posedge clk) begin
    if (!clr_n_i) bit_q <= CLR_VALUE;
    else          bit_q <= d_i;
  end

  assign q_o = bit_q;
endmodule

module lhr_bit_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic load_i,
  input  logic d_i,
  output logic q_o
);
  logic bit_d;
  logic bit_q;

  // sel=load: 0 recirculates the stored bit, 1 takes the new data
  lhr_mux2 u_mux (
    .a_i  (bit_q),
    .b_i  (d_i),
    .sel_i(load_i),
    .y_o  (bit_d)
  );

  lhr_dff_sc #(.CLR_VALUE(RESET_BIT)) u_dff (
    .clk    (clk),
    .clr_n_i(rst_n_i),
    .d_i    (bit_d),
    .q_o    (bit_q)
  );

  assign q_o = bit_q;
endmodule

module load_hold_register #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      lhr_bit_cell #(.RESET_BIT(RESET_VALUE[i])) u_cell (
        .clk    (clk),
        .rst_n_i(rst_n),
        .load_i (load),
        .d_i    (d[i]),
        .q_o    (q[i])
      );
    end
  endgenerate

  assign q_n = ~q;
endmodule

// File: tb/tb_load_hold_register.sv
// tb/tb_load_hold_register.sv - directed bench for load_hold_register (8-bit and 1-bit builds)
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.

module tb_load_hold_register;
  logic       clk;
  logic       rst_n, load;
  logic [7:0] d, q, q_n;
  logic       rst1_n, load1, d1, q1, q1_n;
  int         n_cmp, n_mis;

  load_hold_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .d    (d),
    .q    (q),
    .q_n  (q_n)
  );

  load_hold_register #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (
    .clk  (clk),
    .rst_n(rst1_n),
    .load (load1),
    .d    (d1),
    .q    (q1),
    .q_n  (q1_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;

    // 1: reset wins over load
    rst_n = 1'b0; load = 1'b1; d = 8'hFF;
    rst1_n = 1'b0; load1 = 1'b1; d1 = 1'b0;
    tick();
    check_val("rst_q", q, 8'h00);
    check_val("rst_qn", q_n, 8'hFF);
    check_val("w1_rst_q", {7'b0, q1}, 8'h01);
    check_val("w1_rst_qn", {7'b0, q1_n}, 8'h00);

    // 2: load with one-cycle latency
    rst_n = 1'b1; load = 1'b1; d = 8'hA5;
    #2;
    check_val("pre_load_q", q, 8'h00);
    tick();
    check_val("load_q", q, 8'hA5);
    check_val("load_qn", q_n, 8'h5A);

    // 3: hold across edges, d toggling between edges
    load = 1'b0; d = 8'h00;
    for (int k = 0; k < 3; k++) begin
      #2 d = 8'hFF;
      #2 d = 8'h3C;
      check_val("hold_mid_q", q, 8'hA5);
      tick();
      check_val("hold_q", q, 8'hA5);
    end

    // 4: hold then reload
    load = 1'b0; d = 8'hFF;
    tick();
    check_val("hold2_q", q, 8'hA5);
    load = 1'b1;
    tick();
    check_val("reload_q", q, 8'hFF);
    check_val("reload_qn", q_n, 8'h00);

    // 5: reset pulse between edges is ignored; reset across an edge applies
    load = 1'b0; d = 8'h12;
    #2 rst_n = 1'b0;
    #1 check_val("async_none_q", q, 8'hFF);
    #1 rst_n = 1'b1;
    tick();
    check_val("pulse_q", q, 8'hFF);
    @(negedge clk);
    check_val("negedge_q", q, 8'hFF);
    tick();
    rst_n = 1'b0; load = 1'b1; d = 8'h77;
    tick();
    check_val("midrst_q", q, 8'h00);
    check_val("midrst_qn", q_n, 8'hFF);
    rst_n = 1'b1; d = 8'hC3;
    tick();
    check_val("recover_q", q, 8'hC3);
    check_val("recover_qn", q_n, 8'h3C);

    // 6: WIDTH=1, RESET_VALUE=1
    rst1_n = 1'b1; load1 = 1'b1; d1 = 1'b0;
    tick();
    check_val("w1_load_q", {7'b0, q1}, 8'h00);
    check_val("w1_load_qn", {7'b0, q1_n}, 8'h01);
    load1 = 1'b0; d1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("w1_hold_q", {7'b0, q1}, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
